// File: rtl/venera_pkg.sv
// rtl/venera_pkg.sv - shared widths and loader state encoding for the venera memory subsystem
package venera_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        LOAD_HI = 2'd0,
        LOAD_LO = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } loader_state_t;

endpackage

// File: rtl/venera_mem_subsystem_if.sv
// rtl/venera_mem_subsystem_if.sv - CPU memory buses, loader byte stream and status bundle
interface venera_mem_subsystem_if;
    import venera_pkg::*;

    // instruction bus
    logic                instruction_rd;
    logic [ADDR_W-1:0]   instruction_address;
    logic [DATA_W-1:0]   instruction_data;

    // data bus
    logic                data_wr;
    logic [ADDR_W-1:0]   data_address_wr;
    logic [DATA_W-1:0]   data_in;
    logic                data_rd;
    logic [ADDR_W-1:0]   data_address_rd;
    logic [DATA_W-1:0]   data_out;

    // program loader stream and status
    logic                load_valid;
    logic [7:0]          load_byte;
    logic                load_last;
    logic                load_ready;
    logic [ADDR_W:0]     load_words;
    logic                load_overflow;
    logic                cpu_areset;

    // CPU core plus program source side
    modport master (
        output instruction_rd, instruction_address,
        input  instruction_data,
        output data_wr, data_address_wr, data_in, data_rd, data_address_rd,
        input  data_out,
        output load_valid, load_byte, load_last,
        input  load_ready, load_words, load_overflow, cpu_areset
    );

    // memory subsystem side
    modport slave (
        input  instruction_rd, instruction_address,
        output instruction_data,
        input  data_wr, data_address_wr, data_in, data_rd, data_address_rd,
        output data_out,
        input  load_valid, load_byte, load_last,
        output load_ready, load_words, load_overflow, cpu_areset
    );

endinterface

// File: rtl/sync_ram_1w1r.sv
// rtl/sync_ram_1w1r.sv - one write port, one registered read port, read-before-write
module sync_ram_1w1r #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // storage array: contents survive reset so a reload only overwrites what it touches
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // registered read sees the pre-write contents on a same-address collision; holds when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/venera_mem_subsystem.sv
// rtl/venera_mem_subsystem.sv - instruction/data RAMs plus program loader holding the CPU in reset
module venera_mem_subsystem
    import venera_pkg::*;
(
    input  logic                 clk,
    input  logic                 areset,
    venera_mem_subsystem_if.slave bus
);

    loader_state_t      state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W:0]    words_q, words_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         hi_q, hi_d;
    logic               cpu_rst_q;

    logic               load_ready;
    logic               handshake;
    logic               run;
    logic               imem_we;
    logic [DATA_W-1:0]  imem_wdata;
    logic [DATA_W-1:0]  imem_rdata;
    logic [DATA_W-1:0]  dmem_rdata;

    assign load_ready = (state_q == LOAD_HI) || (state_q == LOAD_LO);
    assign handshake  = bus.load_valid && load_ready;
    assign run        = (state_q == RUN);

    // loader next-state: assemble big-endian words, stop on last byte or a full memory
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        words_d    = words_q;
        overflow_d = overflow_q;
        hi_d       = hi_q;
        imem_we    = 1'b0;
        imem_wdata = {hi_q, bus.load_byte};
        case (state_q)
            LOAD_HI: begin
                if (handshake) begin
                    hi_d = bus.load_byte;
                    if (bus.load_last) begin
                        imem_we    = 1'b1;
                        imem_wdata = {bus.load_byte, 8'h00};
                        ptr_d      = ptr_q + 1'b1;
                        words_d    = words_q + 1'b1;
                        state_d    = RELEASE;
                    end else begin
                        state_d = LOAD_LO;
                    end
                end
            end
            LOAD_LO: begin
                if (handshake) begin
                    imem_we = 1'b1;
                    ptr_d   = ptr_q + 1'b1;
                    words_d = words_q + 1'b1;
                    if (bus.load_last) begin
                        state_d = RELEASE;
                    end else if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                        overflow_d = 1'b1;
                        state_d    = RELEASE;
                    end else begin
                        state_d = LOAD_HI;
                    end
                end
            end
            RELEASE: state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = LOAD_HI;
        endcase
    end

    // loader registers; CPU reset release is registered off the next state so it is glitch-free
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q    <= LOAD_HI;
            ptr_q      <= '0;
            words_q    <= '0;
            overflow_q <= 1'b0;
            hi_q       <= '0;
            cpu_rst_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            words_q    <= words_d;
            overflow_q <= overflow_d;
            hi_q       <= hi_d;
            cpu_rst_q  <= (state_d == RUN);
        end
    end

    sync_ram_1w1r #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) imem (
        .clk   (clk),
        .rst_n (areset),
        .we    (imem_we),
        .waddr (ptr_q),
        .wdata (imem_wdata),
        .re    (bus.instruction_rd && run),
        .raddr (bus.instruction_address),
        .rdata (imem_rdata)
    );

    sync_ram_1w1r #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dmem (
        .clk   (clk),
        .rst_n (areset),
        .we    (bus.data_wr && run),
        .waddr (bus.data_address_wr),
        .wdata (bus.data_in),
        .re    (bus.data_rd && run),
        .raddr (bus.data_address_rd),
        .rdata (dmem_rdata)
    );

    assign bus.instruction_data = imem_rdata;
    assign bus.data_out         = dmem_rdata;
    assign bus.load_ready       = load_ready;
    assign bus.load_words       = words_q;
    assign bus.load_overflow    = overflow_q;
    assign bus.cpu_areset       = cpu_rst_q;

endmodule

// File: tb/tb_venera_mem_subsystem.sv
// tb/tb_venera_mem_subsystem.sv - directed table-driven bench for venera_mem_subsystem
module tb_venera_mem_subsystem;

    logic clk = 1'b0;
    logic areset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    venera_mem_subsystem_if bus ();

    venera_mem_subsystem dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [7:0]  waddr;
        logic [15:0] din;
        logic        rd;
        logic [7:0]  raddr;
        logic [15:0] exp_out;
    } dvec_t;

    dvec_t dvecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.instruction_rd      = 1'b0;
        bus.instruction_address = '0;
        bus.data_wr             = 1'b0;
        bus.data_address_wr     = '0;
        bus.data_in             = '0;
        bus.data_rd             = 1'b0;
        bus.data_address_rd     = '0;
        bus.load_valid          = 1'b0;
        bus.load_byte           = '0;
        bus.load_last           = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        areset = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        areset = 1'b1;
    endtask

    // called at a negedge; presents one byte for exactly one edge
    task automatic send_byte(input logic [7:0] b, input logic last);
        bus.load_valid = 1'b1;
        bus.load_byte  = b;
        bus.load_last  = last;
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic ifetch(input string name, input logic [7:0] addr, input logic [15:0] exp);
        bus.instruction_rd      = 1'b1;
        bus.instruction_address = addr;
        @(negedge clk);
        bus.instruction_rd = 1'b0;
        check(name, bus.instruction_data, exp);
    endtask

    initial begin
        dvecs[0] = '{1'b1, 8'h05, 16'hBEEF, 1'b0, 8'h00, 16'h0000};
        dvecs[1] = '{1'b1, 8'h05, 16'h1111, 1'b1, 8'h05, 16'hBEEF};
        dvecs[2] = '{1'b0, 8'h00, 16'h0000, 1'b1, 8'h05, 16'h1111};
        dvecs[3] = '{1'b1, 8'h0A, 16'h00FF, 1'b0, 8'h05, 16'h1111};
        dvecs[4] = '{1'b0, 8'h00, 16'h0000, 1'b1, 8'h0A, 16'h00FF};
        dvecs[5] = '{1'b1, 8'hFF, 16'hA5A5, 1'b1, 8'h05, 16'h1111};
        dvecs[6] = '{1'b0, 8'h00, 16'h0000, 1'b1, 8'hFF, 16'hA5A5};
        dvecs[7] = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h05, 16'hA5A5};

        idle_inputs();
        do_reset();

        check("rst_instruction_data", bus.instruction_data, 16'h0000);
        check("rst_data_out", bus.data_out, 16'h0000);
        check("rst_load_ready", bus.load_ready, 1'b1);
        check("rst_load_words", bus.load_words, 9'd0);
        check("rst_load_overflow", bus.load_overflow, 1'b0);
        check("rst_cpu_areset", bus.cpu_areset, 1'b0);

        // four-byte program with release timing
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        check("load_words_after_word0", bus.load_words, 9'd1);
        send_byte(8'h56, 1'b0);
        check("cpu_held_mid_load", bus.cpu_areset, 1'b0);
        send_byte(8'h78, 1'b1);
        check("cpu_held_in_release", bus.cpu_areset, 1'b0);
        check("ready_low_in_release", bus.load_ready, 1'b0);
        check("load_words_4byte", bus.load_words, 9'd2);
        @(negedge clk);
        check("cpu_released", bus.cpu_areset, 1'b1);

        // instruction port in RUN, then hold with rd low
        ifetch("imem0_4byte", 8'h00, 16'h1234);
        ifetch("imem1_4byte", 8'h01, 16'h5678);
        bus.instruction_address = 8'h00;
        repeat (2) @(negedge clk);
        check("instruction_hold", bus.instruction_data, 16'h5678);

        // data port vectors, including same-address read/write collision
        for (int i = 0; i < 8; i++) begin
            bus.data_wr         = dvecs[i].wr;
            bus.data_address_wr = dvecs[i].waddr;
            bus.data_in         = dvecs[i].din;
            bus.data_rd         = dvecs[i].rd;
            bus.data_address_rd = dvecs[i].raddr;
            @(negedge clk);
            check($sformatf("dvec%0d_data_out", i), bus.data_out, dvecs[i].exp_out);
        end
        idle_inputs();

        // asynchronous reset in the middle of a load, then a short reload
        do_reset();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        check("midload_words_before_reset", bus.load_words, 9'd1);
        #2 areset = 1'b0;
        #1;
        check("async_rst_cpu_areset", bus.cpu_areset, 1'b0);
        check("async_rst_load_words", bus.load_words, 9'd0);
        @(negedge clk);
        areset = 1'b1;
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b1);
        check("reload_words", bus.load_words, 9'd1);
        @(negedge clk);
        ifetch("reload_imem0", 8'h00, 16'h0000);
        ifetch("reload_imem1_kept", 8'h01, 16'h5678);

        // odd-length program pads the final low byte with zero
        do_reset();
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        send_byte(8'hEF, 1'b1);
        check("odd_load_words", bus.load_words, 9'd2);
        check("odd_overflow", bus.load_overflow, 1'b0);
        @(negedge clk);
        ifetch("odd_imem0", 8'h00, 16'hABCD);
        ifetch("odd_imem1", 8'h01, 16'hEF00);

        // 512 bytes with no last marker fill memory and flag overflow
        do_reset();
        for (int i = 0; i < 512; i++) begin
            send_byte(8'(i), 1'b0);
        end
        check("ovf_load_words", bus.load_words, 9'd256);
        check("ovf_flag", bus.load_overflow, 1'b1);
        check("ovf_ready_low", bus.load_ready, 1'b0);
        bus.load_valid = 1'b1;
        bus.load_byte  = 8'h99;
        @(negedge clk);
        check("ovf_cpu_released", bus.cpu_areset, 1'b1);
        repeat (3) @(negedge clk);
        check("ovf_extra_byte_ignored", bus.load_words, 9'd256);
        check("ovf_ready_low_run", bus.load_ready, 1'b0);
        bus.load_valid = 1'b0;
        ifetch("ovf_imem0", 8'h00, 16'h0001);
        ifetch("ovf_imem255", 8'hFF, 16'hFEFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/venera_mem_subsystem.md
# venera_mem_subsystem

Memory-side responder for the venera_cpu_1 core: serves the CPU's instruction-read bus and data read/write bus with one-cycle-latency synchronous RAMs. Also contains a program-loader FSM that fills instruction memory from an external byte stream after reset. The loader holds the CPU in reset until loading completes. It sits beside the CPU at system top level, on the opposite end of both CPU memory buses.

## Interface
- ADDR_W, 8, address width of both memories
- DATA_W, 16, word width of both memories
- DEPTH, 256, words per memory (2**ADDR_W)

- clk  in  1  system clock
- areset  in  1  asynchronous, active-low reset
- instruction_rd  in  1  instruction read strobe from CPU
- instruction_address  in  ADDR_W  instruction read address
- instruction_data  out  DATA_W  registered instruction word
- data_wr  in  1  data write strobe
- data_address_wr  in  ADDR_W  data write address
- data_in  in  DATA_W  data write word
- data_rd  in  1  data read strobe
- data_address_rd  in  ADDR_W  data read address
- data_out  out  DATA_W  registered data word
- load_valid  in  1  loader byte valid
- load_byte  in  8  loader byte; high byte of each word first
- load_last  in  1  marks final byte of program, qualified by handshake
- load_ready  out  1  loader can accept byte
- load_words  out  ADDR_W+1  number of instruction words written
- load_overflow  out  1  sticky: program exceeded DEPTH words
- cpu_areset  out  1  active-low reset to the CPU's areset input

## Operation
- FSM states: LOAD_HI, LOAD_LO, RELEASE, RUN. Reset state is LOAD_HI.
- Byte handshake: a byte is taken on a clk edge with load_valid=1 and load_ready=1. load_ready=1 only in LOAD_HI and LOAD_LO.
- LOAD_HI with handshake:
  - latch byte into hi register.
  - If load_last=1: write {byte, 8'h00} to imem[ptr], increment ptr and load_words, go to RELEASE.
  - Otherwise go to LOAD_LO.
- LOAD_LO with handshake: write {hi, byte} to imem[ptr], increment ptr and load_words.
  - Go to RELEASE if load_last=1 or ptr was DEPTH-1. In the second case without load_last, set load_overflow=1.
  - Otherwise go to LOAD_HI.
- Bytes offered after overflow are not accepted (load_ready=0).
- RELEASE: exactly one cycle, then RUN. RUN is terminal until areset.
- Loader stream is ignored in RELEASE and RUN.
- cpu_areset=0 in LOAD_HI, LOAD_LO and RELEASE; 1 in RUN. It is driven from a register, glitch-free.
- Instruction port:
  - In RUN, instruction_rd=1 at edge N gives instruction_data=imem[instruction_address] after edge N.
  - instruction_data holds its value when instruction_rd=0.
  - Instruction reads outside RUN are ignored.
- Data port writes: data_wr=1 at an edge writes data_in to dmem[data_address_wr] (RUN only).
- Data port reads: data_rd=1 gives data_out=dmem[data_address_rd] after the edge; data_out holds otherwise (RUN only).
- Read and write to the same address on the same edge: read returns the old value (read-before-write). The new value is visible on the next read.
- Data read and write accesses outside RUN are ignored.

## Timing
- Reset values: instruction_data=0, data_out=0, load_ready=1, load_words=0, load_overflow=0, cpu_areset=0, ptr=0, hi=0.
- Memory contents are not cleared by reset. Reset mid-load restarts at address 0 and overwrites from there.
- Read latency is 1 cycle on both ports. Write latency is 0 cycles (committed at the edge).
- Maximum byte throughput is one byte per cycle. A word is written on the edge that accepts its low byte.
- Release timing: cpu_areset rises exactly 2 edges after the edge accepting the last byte (1 edge into RELEASE, 1 edge into RUN).
- Asynchronous assertion of areset forces cpu_areset=0 immediately. Deassertion is taken at the clk edge; the CPU's own reset synchronizer handles release.

## Structure
- Shared package venera_pkg holds:
  - ADDR_W, DATA_W and DEPTH defaults
  - loader state enum {LOAD_HI, LOAD_LO, RELEASE, RUN}
- Sub-module sync_ram_1w1r: one synchronous write port, one registered read port with read enable, read-before-write. It is instantiated twice:
  - imem: write port from the loader, read port from the instruction bus.
  - dmem: write and read ports both from the data bus.
- Loader FSM, ptr, counters and the cpu_areset register live in the top.

## Test plan
- Load 4 bytes 12,34,56,78 with load_last on 78 -> imem[0]=1234, imem[1]=5678, load_words=2. cpu_areset stays 0 until 2 edges after the 78 handshake, then 1.
- Odd program: 3 bytes AB,CD,EF with load_last on EF -> imem[1]=EF00, load_words=2, load_overflow=0.
- 512 bytes, no load_last -> load_words=256, load_overflow=1, load_ready=0, RUN reached. A 513th byte with load_valid=1 is never accepted.
- In RUN: write dmem[05]=BEEF, then data_rd at 05 on the same edge as data_wr dmem[05]=1111 -> data_out=BEEF. Next read -> 1111.
- In RUN: instruction_rd=1 at address 1 -> instruction_data=5678 one cycle later. Value holds while instruction_rd=0.
- Assert areset mid-load after 3 bytes -> cpu_areset=0 and load_words=0 immediately. Reload of 2 bytes 0000 -> imem[0]=0000, and imem[1] keeps its previous contents.
